// File: rtl/r_fifo_burst.sv
// AXI R-channel beat buffer for the crossbar read-return path, with optional
// store-and-forward that holds beats back until their burst's RLAST has been stored.
module r_fifo_burst_entry #(
  parameter int W = 1
) (
  input  logic         ACLK,
  input  logic         ARESETn,
  input  logic         we,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge ACLK or negedge ARESETn)
    if (!ARESETn) q <= '0;
    else if (we)  q <= d;
endmodule

module r_fifo_burst #(
  parameter  int ID_WIDTH   = 4,
  parameter  int DATA_WIDTH = 32,
  parameter  int DEPTH      = 8,
  parameter  int STORE_FWD  = 0,
  parameter  int AFULL_LVL  = DEPTH - 2,
  localparam int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic [ID_WIDTH-1:0]   s_RID,
  input  logic [DATA_WIDTH-1:0] s_RDATA,
  input  logic [1:0]            s_RRESP,
  input  logic                  s_RLAST,
  input  logic                  s_RVALID,
  output logic                  s_RREADY,
  output logic [ID_WIDTH-1:0]   m_RID,
  output logic [DATA_WIDTH-1:0] m_RDATA,
  output logic [1:0]            m_RRESP,
  output logic                  m_RLAST,
  output logic                  m_RVALID,
  input  logic                  m_RREADY,
  output logic [CNT_W-1:0]      count,
  output logic [CNT_W-1:0]      burst_cnt,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  sf_bypass
);
  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [DATA_WIDTH-1:0] data;
    logic [1:0]            resp;
    logic                  last;
  } beat_t;

  localparam int               BEAT_W   = $bits(beat_t);
  localparam int               PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_AF   = CNT_W'(AFULL_LVL);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [PTR_W-1:0]              wr_ptr, rd_ptr;
  logic [DEPTH-1:0][BEAT_W-1:0]  ent_q;
  logic [DEPTH-1:0]              ent_we;
  beat_t                         wr_beat, rd_beat;
  logic                          push, pop, push_last, pop_last;
  logic [CNT_W-1:0]              count_nxt, burst_nxt;

  assign wr_beat = '{id: s_RID, data: s_RDATA, resp: s_RRESP, last: s_RLAST};
  assign rd_beat = beat_t'(ent_q[rd_ptr]);

  assign m_RID   = rd_beat.id;
  assign m_RDATA = rd_beat.data;
  assign m_RRESP = rd_beat.resp;
  assign m_RLAST = rd_beat.last;

  // Only register state feeds s_RREADY, so a pop at full never lets a push through.
  assign full        = (count == CNT_FULL);
  assign empty       = (count == '0);
  assign almost_full = (count >= CNT_AF);
  assign s_RREADY    = ~full;

  assign push      = s_RVALID & s_RREADY;
  assign pop       = m_RVALID & m_RREADY;
  assign push_last = push & s_RLAST;
  assign pop_last  = pop & m_RLAST;

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    assign ent_we[i] = push && (wr_ptr == PTR_W'(i));
    r_fifo_burst_entry #(.W(BEAT_W)) u_ent (
      .ACLK    (ACLK),
      .ARESETn (ARESETn),
      .we      (ent_we[i]),
      .d       (wr_beat),
      .q       (ent_q[i])
    );
  end

  always_comb begin
    count_nxt = count;
    if (push && !pop)      count_nxt = count + CNT_ONE;
    else if (pop && !push) count_nxt = count - CNT_ONE;
    burst_nxt = burst_cnt;
    if (push_last && !pop_last)      burst_nxt = burst_cnt + CNT_ONE;
    else if (pop_last && !push_last) burst_nxt = burst_cnt - CNT_ONE;
  end

  // Pointers wrap explicitly so any DEPTH works, not just powers of two.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      burst_cnt <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_ONE;
      count     <= count_nxt;
      burst_cnt <= burst_nxt;
    end
  end

  if (STORE_FWD != 0) begin : g_sf
    logic drain, bypass, drain_set;
    // A full buffer with no complete burst can only make progress by releasing the
    // partial burst; drain holds that release until its RLAST beat leaves.
    assign drain_set = (count_nxt == CNT_FULL) && (burst_nxt == '0);
    always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
        drain  <= 1'b0;
        bypass <= 1'b0;
      end else begin
        drain  <= drain_set | (drain & ~pop_last);
        bypass <= bypass | drain_set;
      end
    end
    assign m_RVALID  = ~empty & ((burst_cnt != '0) | drain);
    assign sf_bypass = bypass;
  end else begin : g_ct
    assign m_RVALID  = ~empty;
    assign sf_bypass = 1'b0;
  end
endmodule

// File: tb/tb_r_fifo_burst.sv
// Directed and randomised bench for r_fifo_burst: DEPTH=8 cut-through,
// DEPTH=5 cut-through, and DEPTH=4 store-and-forward instances on shared inputs.
module tb_r_fifo_burst;
  logic        ACLK, ARESETn;
  logic [3:0]  s_RID;
  logic [31:0] s_RDATA;
  logic [1:0]  s_RRESP;
  logic        s_RLAST, s_RVALID, m_RREADY;

  logic        a_srdy, a_mvld, a_mlast, a_full, a_empty, a_af, a_byp;
  logic [3:0]  a_mid, a_cnt, a_bcnt;
  logic [31:0] a_mdata;
  logic [1:0]  a_mresp;

  logic        b_srdy, b_mvld, b_mlast, b_full, b_empty, b_af, b_byp;
  logic [3:0]  b_mid;
  logic [2:0]  b_cnt, b_bcnt;
  logic [31:0] b_mdata;
  logic [1:0]  b_mresp;

  logic        c_srdy, c_mvld, c_mlast, c_full, c_empty, c_af, c_byp;
  logic [3:0]  c_mid;
  logic [2:0]  c_cnt, c_bcnt;
  logic [31:0] c_mdata;
  logic [1:0]  c_mresp;

  int n_assert = 0;
  int n_fail   = 0;

  r_fifo_burst #(.DEPTH(8)) u_a (
    .ACLK(ACLK), .ARESETn(ARESETn), .s_RID(s_RID), .s_RDATA(s_RDATA), .s_RRESP(s_RRESP),
    .s_RLAST(s_RLAST), .s_RVALID(s_RVALID), .s_RREADY(a_srdy), .m_RID(a_mid),
    .m_RDATA(a_mdata), .m_RRESP(a_mresp), .m_RLAST(a_mlast), .m_RVALID(a_mvld),
    .m_RREADY(m_RREADY), .count(a_cnt), .burst_cnt(a_bcnt), .full(a_full),
    .empty(a_empty), .almost_full(a_af), .sf_bypass(a_byp));

  r_fifo_burst #(.DEPTH(5)) u_b (
    .ACLK(ACLK), .ARESETn(ARESETn), .s_RID(s_RID), .s_RDATA(s_RDATA), .s_RRESP(s_RRESP),
    .s_RLAST(s_RLAST), .s_RVALID(s_RVALID), .s_RREADY(b_srdy), .m_RID(b_mid),
    .m_RDATA(b_mdata), .m_RRESP(b_mresp), .m_RLAST(b_mlast), .m_RVALID(b_mvld),
    .m_RREADY(m_RREADY), .count(b_cnt), .burst_cnt(b_bcnt), .full(b_full),
    .empty(b_empty), .almost_full(b_af), .sf_bypass(b_byp));

  r_fifo_burst #(.DEPTH(4), .STORE_FWD(1)) u_c (
    .ACLK(ACLK), .ARESETn(ARESETn), .s_RID(s_RID), .s_RDATA(s_RDATA), .s_RRESP(s_RRESP),
    .s_RLAST(s_RLAST), .s_RVALID(s_RVALID), .s_RREADY(c_srdy), .m_RID(c_mid),
    .m_RDATA(c_mdata), .m_RRESP(c_mresp), .m_RLAST(c_mlast), .m_RVALID(c_mvld),
    .m_RREADY(m_RREADY), .count(c_cnt), .burst_cnt(c_bcnt), .full(c_full),
    .empty(c_empty), .almost_full(c_af), .sf_bypass(c_byp));

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic drv(input logic v, input logic [3:0] id, input logic [31:0] d, input logic l);
    s_RVALID = v;
    s_RID    = id;
    s_RDATA  = d;
    s_RRESP  = d[1:0];
    s_RLAST  = l;
  endtask

  task automatic do_reset();
    ARESETn  = 1'b0;
    m_RREADY = 1'b0;
    drv(1'b0, 4'h0, 32'h0, 1'b0);
    step();
    ARESETn = 1'b1;
    step();
  endtask

  initial begin
    logic [38:0] q[$];
    logic [38:0] nb;
    logic        do_push, do_pop, prev_stall;
    int          nlast;

    ARESETn = 1'b0;
    m_RREADY = 1'b0;
    drv(1'b0, 4'h0, 32'h0, 1'b0);
    do_reset();

    // reset state
    chk("rst_count", 64'(a_cnt), 64'(0));
    chk("rst_empty", 64'(a_empty), 64'(1));
    chk("rst_full", 64'(a_full), 64'(0));
    chk("rst_afull", 64'(a_af), 64'(0));
    chk("rst_srdy", 64'(a_srdy), 64'(1));
    chk("rst_mvld", 64'(a_mvld), 64'(0));
    chk("rst_mdata", 64'(a_mdata), 64'(0));
    chk("rst_byp", 64'(c_byp), 64'(0));

    // fill DEPTH=8 with one 8-beat burst
    for (int i = 0; i < 8; i++) begin
      drv(1'b1, 4'h1, 32'(i), i == 7);
      step();
      chk("fill_count", 64'(a_cnt), 64'(i + 1));
      chk("fill_afull", 64'(a_af), 64'(i + 1 >= 6));
    end
    chk("fill_full", 64'(a_full), 64'(1));
    chk("fill_srdy", 64'(a_srdy), 64'(0));
    chk("fill_bcnt", 64'(a_bcnt), 64'(1));

    // pop at full while offering a beat: no push-through, ready returns after the edge
    drv(1'b1, 4'h1, 32'hAA, 1'b0);
    m_RREADY = 1'b1;
    chk("fb_srdy_lo", 64'(a_srdy), 64'(0));
    chk("fb_data0", 64'(a_mdata), 64'(0));
    step();
    chk("fb_count", 64'(a_cnt), 64'(7));
    chk("fb_srdy_hi", 64'(a_srdy), 64'(1));
    drv(1'b0, 4'h0, 32'h0, 1'b0);
    for (int i = 1; i < 8; i++) begin
      chk("drain_vld", 64'(a_mvld), 64'(1));
      chk("drain_data", 64'(a_mdata), 64'(i));
      chk("drain_last", 64'(a_mlast), 64'(i == 7));
      step();
    end
    chk("drain_empty", 64'(a_empty), 64'(1));
    chk("drain_bcnt", 64'(a_bcnt), 64'(0));

    // DEPTH=5 streaming with continuous ready
    do_reset();
    m_RREADY = 1'b1;
    for (int c = 0; c < 24; c++) begin
      drv(c < 23, 4'h3, 32'(100 + c), (c % 4) == 3);
      if (c > 0) begin
        chk("str_vld", 64'(b_mvld), 64'(1));
        chk("str_data", 64'(b_mdata), 64'(100 + c - 1));
        chk("str_count", 64'(b_cnt), 64'(1));
      end
      step();
    end
    chk("str_empty", 64'(b_empty), 64'(1));
    chk("str_bcnt", 64'(b_bcnt), 64'(0));

    // store-and-forward: 3-beat burst hidden until RLAST stored
    do_reset();
    m_RREADY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drv(1'b1, 4'h2, 32'(32'h200 + i), i == 2);
      chk("sf_hidden", 64'(c_mvld), 64'(0));
      step();
    end
    drv(1'b0, 4'h0, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("sf_vld", 64'(c_mvld), 64'(1));
      chk("sf_id", 64'(c_mid), 64'(2));
      chk("sf_data", 64'(c_mdata), 64'(32'h200 + i));
      step();
    end
    chk("sf_bcnt", 64'(c_bcnt), 64'(0));
    chk("sf_empty", 64'(c_empty), 64'(1));

    // store-and-forward overflow: 6-beat burst into DEPTH=4
    do_reset();
    chk("ovf_byp0", 64'(c_byp), 64'(0));
    for (int i = 0; i < 4; i++) begin
      drv(1'b1, 4'h5, 32'(32'h300 + i), 1'b0);
      step();
    end
    drv(1'b0, 4'h0, 32'h0, 1'b0);
    chk("ovf_full", 64'(c_full), 64'(1));
    chk("ovf_bcnt", 64'(c_bcnt), 64'(0));
    chk("ovf_byp", 64'(c_byp), 64'(1));
    chk("ovf_vld", 64'(c_mvld), 64'(1));
    m_RREADY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("ovf_pvld", 64'(c_mvld), 64'(1));
      chk("ovf_pdata", 64'(c_mdata), 64'(32'h300 + i));
      step();
    end
    chk("ovf_empty", 64'(c_empty), 64'(1));
    m_RREADY = 1'b0;
    drv(1'b1, 4'h5, 32'h304, 1'b0);
    step();
    drv(1'b1, 4'h5, 32'h305, 1'b1);
    chk("ovf_tail_vld", 64'(c_mvld), 64'(1));
    chk("ovf_tail_data", 64'(c_mdata), 64'(32'h304));
    step();
    drv(1'b0, 4'h0, 32'h0, 1'b0);
    m_RREADY = 1'b1;
    chk("ovf_t4_last", 64'(c_mlast), 64'(0));
    step();
    chk("ovf_t5_data", 64'(c_mdata), 64'(32'h305));
    chk("ovf_t5_last", 64'(c_mlast), 64'(1));
    step();
    chk("ovf_end_empty", 64'(c_empty), 64'(1));
    chk("ovf_end_bcnt", 64'(c_bcnt), 64'(0));
    chk("ovf_byp_sticky", 64'(c_byp), 64'(1));
    m_RREADY = 1'b0;
    drv(1'b1, 4'h6, 32'h400, 1'b0);
    step();
    drv(1'b0, 4'h0, 32'h0, 1'b0);
    chk("ovf_drain_clr", 64'(c_mvld), 64'(0));
    chk("ovf_new_cnt", 64'(c_cnt), 64'(1));

    // asynchronous reset between edges with count=3
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      drv(1'b1, 4'h7, 32'(32'h11 * i), i == 3);
      step();
    end
    drv(1'b0, 4'h0, 32'h0, 1'b0);
    chk("ar_pre_cnt", 64'(a_cnt), 64'(3));
    chk("ar_pre_vld", 64'(a_mvld), 64'(1));
    #3 ARESETn = 1'b0;
    #1;
    chk("ar_cnt", 64'(a_cnt), 64'(0));
    chk("ar_vld", 64'(a_mvld), 64'(0));
    chk("ar_empty", 64'(a_empty), 64'(1));
    chk("ar_data", 64'(a_mdata), 64'(0));
    chk("ar_srdy", 64'(a_srdy), 64'(1));
    #2 ARESETn = 1'b1;
    step();
    drv(1'b1, 4'h8, 32'h55, 1'b1);
    step();
    drv(1'b0, 4'h0, 32'h0, 1'b0);
    chk("ar_post_vld", 64'(a_mvld), 64'(1));
    chk("ar_post_data", 64'(a_mdata), 64'(32'h55));
    chk("ar_post_cnt", 64'(a_cnt), 64'(1));
    m_RREADY = 1'b1;
    step();
    chk("ar_post_empty", 64'(a_empty), 64'(1));

    // random traffic on DEPTH=8 against a queue model
    do_reset();
    prev_stall = 1'b0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      nlast = 0;
      foreach (q[k]) nlast += int'(q[k][0]);
      chk("rnd_count", 64'(a_cnt), 64'(q.size()));
      chk("rnd_bcnt", 64'(a_bcnt), 64'(nlast));
      chk("rnd_vld", 64'(a_mvld), 64'(q.size() != 0));
      if (q.size() != 0)
        chk("rnd_beat", 64'({a_mid, a_mdata, a_mresp, a_mlast}), 64'(q[0]));
      if (prev_stall) chk("rnd_vld_hold", 64'(a_mvld), 64'(1));
      if (((cyc / 500) % 2) == 0) begin
        s_RVALID = ($urandom_range(0, 3) != 0);
        m_RREADY = ($urandom_range(0, 3) == 0);
      end else begin
        s_RVALID = ($urandom_range(0, 3) == 0);
        m_RREADY = ($urandom_range(0, 3) != 0);
      end
      s_RID   = 4'($urandom);
      s_RDATA = $urandom;
      s_RRESP = 2'($urandom);
      s_RLAST = ($urandom_range(0, 2) == 0);
      nb      = {s_RID, s_RDATA, s_RRESP, s_RLAST};
      do_push = s_RVALID && (q.size() < 8);
      do_pop  = m_RREADY && (q.size() != 0);
      prev_stall = (q.size() != 0) && !m_RREADY;
      step();
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back(nb);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
